button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 178 +++++++++++++++++
 tb/tb_button_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-key synchroniser, debouncer and press/release/long/repeat strobe generator
// Optional feature macro: BTN_AUTO_REPEAT_EN (defined: repeat_pulse active while long-held; undefined: repeat_pulse tied to 0)
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`else
  // The repeat period has no effect in this build; referenced here only so it is not left dangling.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
  assign repeat_pulse      = '0;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]       sync_q;
    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             from_long_q, from_long_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic             rep_q, rep_d;
`endif

    // Two-flop synchroniser; idles at 1 (released) so reset never looks like a press
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], btn_n[i]};
    end

    assign s = ~sync_q[1];

    // Next-state, counter and strobe decode for the debounce / hold classifier
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      from_long_d = from_long_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_d       = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (s) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_d     = DB_REL;
            cnt_d       = '0;
            from_long_d = 1'b0;
          end else if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LONG: begin
          if (!s) begin
            state_d     = DB_REL;
            cnt_d       = '0;
            from_long_d = 1'b1;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (cnt_q == REP_LAST) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        DB_REL: begin
          // A bounce back to pressed resumes the hold; from_long stops a second long_pulse
          if (s) begin
            state_d = from_long_q ? LONG : HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        from_long_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_q       <= 1'b0;
`endif
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        from_long_q <= from_long_d;
        level_q     <= level_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        long_q      <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
        rep_q       <= rep_d;
`endif
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign long_pulse[i]    = long_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_pulse[i]  = rep_q;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  wire  [19:0] obs = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(4), .CNT_W(8), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit layout of obs: level[19:16] press[15:12] release[11:8] long[7:4] repeat[3:0]

  task automatic test_reset();
    logic [19:0] e;
    rst   = 1'b0;
    btn_n = 4'hF;
    repeat (3) step();
    e = '0;
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", obs, e); end
    rst = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
  endtask

  task automatic test_clean_press();
    logic [19:0] e;
    btn_n = 4'b1110;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[16] = (t >= 7);
      e[12] = (t == 7);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL clean_press t=%0d got=%h exp=%h", t, obs, e); end
    end
    btn_n = 4'hF;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[16] = (t < 7);
      e[8]  = (t == 7);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL clean_release t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  task automatic test_bounce();
    logic [19:0] e;
    // low for 2 edges, high for 1, then low steady from after edge 3
    for (int t = 1; t <= 14; t++) begin
      if (t == 1 || t >= 4) btn_n = 4'b1101;
      else if (t == 3)      btn_n = 4'b1111;
      step();
      e = '0;
      e[17] = (t >= 10);
      e[13] = (t == 10);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL bounce_press t=%0d got=%h exp=%h", t, obs, e); end
    end
    btn_n = 4'hF;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[17] = (t < 7);
      e[9]  = (t == 7);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL bounce_release t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  task automatic test_long_repeat();
    logic [19:0] e;
    btn_n = 4'b1011;
    for (int t = 1; t <= 72; t++) begin
      if (t == 61) btn_n = 4'hF;
      step();
      e = '0;
      e[18] = (t >= 7) && (t < 67);
      e[14] = (t == 7);
      e[10] = (t == 67);
      e[6]  = (t == 27);
      e[2]  = REP_ON && (t >= 32) && (t <= 62) && ((t - 27) % 5 == 0);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL long_repeat t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  task automatic test_release_bounce_long();
    logic [19:0] e;
    btn_n = 4'b1011;
    for (int t = 1; t <= 60; t++) begin
      if (t == 28)      btn_n = 4'hF;
      else if (t == 30) btn_n = 4'b1011;
      else if (t == 51) btn_n = 4'hF;
      step();
      e = '0;
      e[18] = (t >= 7) && (t < 57);
      e[14] = (t == 7);
      e[10] = (t == 57);
      e[6]  = (t == 27);
      e[2]  = REP_ON && (t == 37 || t == 42 || t == 47 || t == 52);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL rel_bounce_long t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  task automatic test_simultaneous();
    logic [19:0] e;
    btn_n = 4'b0110;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[19:16] = (t >= 7) ? 4'b1001 : 4'b0000;
      e[15:12] = (t == 7) ? 4'b1001 : 4'b0000;
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL simul_press t=%0d got=%h exp=%h", t, obs, e); end
    end
    btn_n = 4'hF;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[19:16] = (t < 7) ? 4'b1001 : 4'b0000;
      e[11:8]  = (t == 7) ? 4'b1001 : 4'b0000;
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL simul_release t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] e;
    btn_n = 4'b1110;
    repeat (7) step();
    e = '0;
    e[16] = 1'b1;
    e[12] = 1'b1;
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL pre_reset_press got=%h exp=%h", obs, e); end
    #2;
    rst = 1'b0;
    #1;
    e = '0;
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
    step();
    rst = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[16] = (t >= 7);
      e[12] = (t == 7);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL requalify t=%0d got=%h exp=%h", t, obs, e); end
    end
    btn_n = 4'hF;
    for (int t = 1; t <= 10; t++) begin
      step();
      e = '0;
      e[16] = (t < 7);
      e[8]  = (t == 7);
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL requalify_release t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_bounce_long();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
